// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared definitions for the register-file write-back arbiter.
//   XLEN       : width of a result and of a register file entry
//   REG_ADDR_W : width of a register index
//   REG_ZERO   : index of the hard-wired zero register (never written)
//   wb_req_t   : one producer's request {valid, addr, data}
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage : wb_arbiter_pkg

// File: rtl/wb_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// wb_starve_ctr
//   Tracks how many consecutive edges port B has been held off and raises
//   boost once that reaches MaxWait, so B is guaranteed a grant.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     b_valid_i  in   port B is presenting a result
//     b_ready_i  in   port B would be accepted this cycle
//     b_fire_i   in   port B transfers at this edge
//     boost_o    out  B has priority over A
// -----------------------------------------------------------------------------
module wb_starve_ctr #(
   parameter int MaxWait = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic b_valid_i,
   input  logic b_ready_i,
   input  logic b_fire_i,
   output logic boost_o
);

   localparam logic [3:0] MAX_W = 4'(MaxWait);

   logic [3:0] cnt_q, cnt_d;
   logic       boost_q, boost_d;

   always_comb begin
      cnt_d   = cnt_q;
      boost_d = boost_q;
      if (b_fire_i) begin
         cnt_d   = 4'd0;
         boost_d = 1'b0;
      end else if (!b_valid_i) begin
         // A withdrawn request restarts the wait; boost is only released by
         // an actual B transfer.
         cnt_d = 4'd0;
      end else if (!b_ready_i) begin
         if (cnt_q != MAX_W) begin
            cnt_d = cnt_q + 4'd1;
         end
         if (cnt_d == MAX_W) begin
            boost_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 4'd0;
         boost_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         boost_q <= boost_d;
      end
   end

   assign boost_o = boost_q;

endmodule : wb_starve_ctr

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-side master of the integer/FP register file. Merges a single-cycle
//   ALU producer (port A) and a multi-cycle FPU/divider producer (port B)
//   into one registered write per cycle. A has fixed priority; B is boosted
//   above A after MaxWait consecutive stalled edges.
//
//   Handshake (both ports): a transfer happens at a rising edge where
//   valid && ready. The producer keeps valid/addr/data stable until then.
//   ready is derived only from the boost state and the OTHER port's valid,
//   never from the port's own valid.
//
//   Optional feature, macro WB_BYPASS_EN: adds rs1/rs2 bypass ports that
//   forward the pending write during the cycle before the register file
//   captures it.
//
//   Ports:
//     clk, rst_n                 clock / asynchronous active-low reset
//     a_valid/a_ready/a_addr/a_data   port A handshake and payload
//     b_valid/b_ready/b_addr/b_data   port B handshake and payload
//     load, rd_addr, rd_i        register file write port (registered)
//     rs1_addr, rs2_addr         read addresses      (WB_BYPASS_EN only)
//     rs1_hit, rs2_hit, fwd_o    bypass match / data (WB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int Size    = 64,
   parameter int MaxWait = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [Size-1:0]       a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_addr,
   input  logic [Size-1:0]       b_data,
   output logic                  load,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [Size-1:0]       rd_i
`ifdef WB_BYPASS_EN
   ,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_hit,
   output logic                  rs2_hit,
   output logic [Size-1:0]       fwd_o
`endif
);

   logic    boost;
   logic    a_fire, b_fire;
   wb_req_t req_a, req_b, win;

   logic                  load_q, load_d;
   logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [Size-1:0]       rd_data_q, rd_data_d;

   // Readiness depends only on boost and the competing valid, so at most one
   // of the two ports can transfer in any cycle.
   always_comb begin
      a_ready = 1'b1;
      b_ready = 1'b0;
      if (boost) begin
         b_ready = 1'b1;
         a_ready = !b_valid;
      end else begin
         a_ready = 1'b1;
         b_ready = !a_valid;
      end
   end

   assign a_fire = a_valid && a_ready;
   assign b_fire = b_valid && b_ready;

   assign req_a = '{valid: a_fire, addr: a_addr, data: a_data};
   assign req_b = '{valid: b_fire, addr: b_addr, data: b_data};

   wb_starve_ctr #(
      .MaxWait (MaxWait)
   ) u_starve (
      .clk       (clk),
      .rst_n     (rst_n),
      .b_valid_i (b_valid),
      .b_ready_i (b_ready),
      .b_fire_i  (b_fire),
      .boost_o   (boost)
   );

   always_comb begin
      win       = b_fire ? req_b : req_a;
      load_d    = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (win.valid) begin
         // Writes to x0 still update address/data but never assert load.
         load_d    = (win.addr != REG_ZERO);
         rd_addr_d = win.addr;
         rd_data_d = win.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q    <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         load_q    <= load_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign load    = load_q;
   assign rd_addr = rd_addr_q;
   assign rd_i    = rd_data_q;

`ifdef WB_BYPASS_EN
   assign rs1_hit = load_q && (rd_addr_q == rs1_addr) && (rs1_addr != REG_ZERO);
   assign rs2_hit = load_q && (rd_addr_q == rs2_addr) && (rs2_addr != REG_ZERO);
   assign fwd_o   = rd_data_q;
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   localparam int SIZE = 64;
   localparam int MAXW = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            a_valid, a_ready, b_valid, b_ready, load;
   logic [4:0]      a_addr, b_addr, rd_addr;
   logic [SIZE-1:0] a_data, b_data, rd_i;
`ifdef WB_BYPASS_EN
   logic [4:0]      rs1_addr, rs2_addr;
   logic            rs1_hit, rs2_hit;
   logic [SIZE-1:0] fwd_o;
`endif

   wb_arbiter #(.Size(SIZE), .MaxWait(MAXW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .load     (load),
      .rd_addr  (rd_addr),
      .rd_i     (rd_i)
`ifdef WB_BYPASS_EN
      ,
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_hit  (rs1_hit),
      .rs2_hit  (rs2_hit),
      .fwd_o    (fwd_o)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Priority rules: A wins unless B has waited MAXW stalled edges; then B
   // wins once. Outputs are the last accepted write, load only if addr!=0.
   bit              m_boost;
   int              m_wait;
   bit              m_load;
   logic [4:0]      m_addr;
   logic [SIZE-1:0] m_data;

   function automatic bit exp_a_ready();
      return m_boost ? !b_valid : 1'b1;
   endfunction

   function automatic bit exp_b_ready();
      return m_boost ? 1'b1 : !a_valid;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_boost = 0; m_wait = 0; m_load = 0; m_addr = '0; m_data = '0;
      end else begin
         bit ar, br, af, bf;
         ar = exp_a_ready();
         br = exp_b_ready();
         af = a_valid && ar;
         bf = b_valid && br;
         if (bf) begin
            m_wait = 0; m_boost = 0;
         end else if (!b_valid) begin
            m_wait = 0;
         end else if (!br) begin
            m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
            if (m_wait == MAXW) m_boost = 1;
         end
         if (bf) begin
            m_load = (b_addr != 0); m_addr = b_addr; m_data = b_data;
         end else if (af) begin
            m_load = (a_addr != 0); m_addr = a_addr; m_data = a_data;
         end else begin
            m_load = 0;
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [4:0] exp_q[$];
   logic [4:0] got_q[$];
   bit         log_en = 0;

   always @(negedge clk) begin
      chk("a_ready", 64'(a_ready), 64'(exp_a_ready()));
      chk("b_ready", 64'(b_ready), 64'(exp_b_ready()));
      chk("load",    64'(load),    64'(m_load));
      chk("rd_addr", 64'(rd_addr), 64'(m_addr));
      chk("rd_i",    rd_i,         m_data);
      chk("boost",   64'(u_dut.boost), 64'(m_boost));
      if (log_en && load) got_q.push_back(rd_addr);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_a(input logic v, input logic [4:0] ad, input logic [SIZE-1:0] d);
      a_valid = v; a_addr = ad; a_data = d;
   endtask

   task automatic put_b(input logic v, input logic [4:0] ad, input logic [SIZE-1:0] d);
      b_valid = v; b_addr = ad; b_data = d;
   endtask

   // ---------------- stimulus ----------------
   logic [4:0] seq [10];
   bit         af, bf;

   initial begin
      rst_n = 1'b0;
      put_a(0, 0, 0);
      put_b(0, 0, 0);
`ifdef WB_BYPASS_EN
      rs1_addr = 0; rs2_addr = 0;
`endif
      #12 rst_n = 1'b1;
      #1;
      chk("reset_load", 64'(load), 64'd0);
      chk("reset_addr", 64'(rd_addr), 64'd0);
      chk("reset_data", rd_i, 64'd0);
      tick();

      // single A write
      put_a(1, 5, 64'hDEAD_BEEF_0000_0001);
      #1 chk("single_a_ready", 64'(a_ready), 64'd1);
      tick();
      a_valid = 0;
      chk("single_load", 64'(load), 64'd1);
      chk("single_addr", 64'(rd_addr), 64'd5);
      chk("single_data", rd_i, 64'hDEAD_BEEF_0000_0001);
      tick();
      chk("single_idle_load", 64'(load), 64'd0);
      chk("single_idle_addr", 64'(rd_addr), 64'd5);
      chk("single_idle_data", rd_i, 64'hDEAD_BEEF_0000_0001);

      // back-to-back A: load every cycle
      for (int i = 0; i < 5; i++) begin
         put_a(1, 5'(i + 1), 64'(i * 32'h111));
         tick();
         chk("b2b_load", 64'(load), 64'd1);
         chk("b2b_addr", 64'(rd_addr), 64'(i + 1));
      end
      a_valid = 0;
      tick();

      // x0 write from B
      put_b(1, 0, 64'hFFFF);
      #1 chk("x0_b_ready", 64'(b_ready), 64'd1);
      tick();
      b_valid = 0;
      chk("x0_load", 64'(load), 64'd0);
      chk("x0_addr", 64'(rd_addr), 64'd0);
      chk("x0_data", rd_i, 64'hFFFF);
      tick();

      // B withdrawn after two stalled cycles: no boost, counter cleared
      put_a(1, 3, 64'h33);
      put_b(1, 7, 64'h1234);
      tick();
      tick();
      chk("stab_cnt2", 64'(u_dut.u_starve.cnt_q), 64'd2);
      b_valid = 0;
      tick();
      chk("stab_cnt0", 64'(u_dut.u_starve.cnt_q), 64'd0);
      chk("stab_boost", 64'(u_dut.boost), 64'd0);
      chk("stab_addr", 64'(rd_addr), 64'd3);
      a_valid = 0;
      tick();

      // contention: 4 A grants then one B grant, twice
      seq = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd7, 5'd3, 5'd3, 5'd3, 5'd3, 5'd7};
      exp_q.delete();
      foreach (seq[i]) exp_q.push_back(seq[i]);
      got_q.delete();
      log_en = 1;
      put_a(1, 3, 64'hA3);
      put_b(1, 7, 64'h1234);
      repeat (10) tick();
      chk("cont_cnt0", 64'(u_dut.u_starve.cnt_q), 64'd0);
      chk("cont_last_data", rd_i, 64'h1234);
      a_valid = 0; b_valid = 0;
      #5;
      log_en = 0;
      chk("cont_grants", 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() != 0 && got_q.size() != 0)
         chk("cont_grant_addr", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      tick();

      // mixed traffic obeying the hold-until-transfer rule
      for (int c = 0; c < 60; c++) begin
         if (!a_valid && $urandom_range(0, 1) == 1)
            put_a(1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         if (!b_valid && $urandom_range(0, 2) == 0)
            put_b(1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
         #1;
         af = a_valid && a_ready;
         bf = b_valid && b_ready;
         tick();
         if (af) a_valid = 0;
         if (bf) b_valid = 0;
      end
      // drain a pending B request; its grant is bounded by MAXW+1 edges
      a_valid = 0;
      for (int c = 0; c < MAXW + 2 && b_valid; c++) begin
         #1;
         bf = b_valid && b_ready;
         tick();
         if (bf) b_valid = 0;
      end
      chk("drain_b_done", 64'(b_valid), 64'd0);
      b_valid = 0;
      tick();

`ifdef WB_BYPASS_EN
      put_a(1, 9, 64'hCAFE_0009);
      rs1_addr = 9; rs2_addr = 0;
      tick();
      a_valid = 0;
      chk("byp_rs1_hit", 64'(rs1_hit), 64'd1);
      chk("byp_rs2_hit", 64'(rs2_hit), 64'd0);
      chk("byp_fwd", fwd_o, 64'hCAFE_0009);
      tick();
      chk("byp_rs1_idle", 64'(rs1_hit), 64'd0);
`endif

      // asynchronous reset with a write pending
      put_a(1, 9, 64'h99);
      tick();
      a_valid = 0;
      chk("pre_rst_load", 64'(load), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_load", 64'(load), 64'd0);
      chk("async_rst_addr", 64'(rd_addr), 64'd0);
      chk("async_rst_data", rd_i, 64'd0);
      #3 rst_n = 1'b1;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side master for the 64-bit integer/FP register file: drives its `load` / `rd_addr` / `rd_i` write port.
- Merges results from two producers:
  - Port A: single-cycle ALU path.
  - Port B: multi-cycle path (FPU/divider).
- Each producer uses a valid/ready handshake. Output is a registered one-write-per-cycle stream.
- Fixed priority to A, with a starvation counter that guarantees B a grant.

Parameters:
- Size, 64, data width of a result and of the register file.
- MaxWait, 4, consecutive stalled cycles of B before B is boosted over A (legal range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  port A result valid
- a_ready  out  1  port A accepted this cycle
- a_addr  in  5  port A destination register
- a_data  in  Size  port A result
- b_valid  in  1  port B result valid
- b_ready  out  1  port B accepted this cycle
- b_addr  in  5  port B destination register
- b_data  in  Size  port B result
- load  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_i  out  Size  register file write data
- rs1_addr, rs2_addr  in  5 each  read addresses (only with WB_BYPASS_EN)
- rs1_hit, rs2_hit  out  1 each  bypass match (only with WB_BYPASS_EN)
- fwd_o  out  Size  bypass data (only with WB_BYPASS_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): load=0, rd_addr=0, rd_i=0, wait counter=0, boost=0. Takes effect immediately, independent of clk.
- Reset mid-operation: a registered write not yet consumed is dropped. Producers must re-present it.
- Handshake (A and B):
  - Transfer occurs when valid && ready at a rising edge.
  - Producer holds valid, addr and data stable until the transfer.
  - ready is combinational from state and the other port's valid; it never depends on its own valid.
- Arbitration:
  - Normal mode (boost=0): a_ready=1; b_ready = !a_valid.
  - Boost mode (boost=1): b_ready=1; a_ready = !b_valid.
  - At most one transfer per cycle.
- Starvation counter (width 4):
  - Increments on each edge where b_valid && !b_ready.
  - Resets to 0 on each B transfer, and whenever b_valid=0.
  - boost sets on the edge where the counter reaches MaxWait.
  - boost clears on the edge of the B transfer.
  - Counter saturates at MaxWait.
- Latency: a transfer at edge N produces load=1, rd_addr=addr, rd_i=data visible after edge N; the register file captures it at edge N+1.
- Idle: with no transfer at an edge, load=0 after that edge; rd_addr and rd_i hold their previous values.
- x0 handling: a transfer with addr=0 is accepted (ready behaviour unchanged) but produces load=0. rd_addr and rd_i still update.
- Back-to-back: continuous A traffic yields load=1 every cycle. No bubble is inserted except the one B grant when boosted.
- Simultaneous a_valid and b_valid with boost=0 and counter=MaxWait-1: A wins this cycle; boost is set at that edge; B wins the next cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds rs1/rs2 bypass ports.
  - rs1_hit = load && (rd_addr == rs1_addr) && (rs1_addr != 0); rs2_hit likewise.
  - fwd_o = rd_i.
  - Purely combinational from the output registers. This covers the one-cycle window before the register file captures the write.
- Undefined: bypass ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - XLEN=64.
  - REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - A wb_req typedef struct {valid, addr, data}.
- One natural sub-module, wb_starve_ctr: the counter plus boost flag. Inputs: b_valid, b_ready, b_fire. Output: boost.
- The top holds the arbitration and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with load=1 pending -> load=0, rd_addr=0, rd_i=0 immediately, before the next clk edge.
- Single A: a_valid=1, a_addr=5, a_data=64'hDEAD_BEEF_0000_0001 for one handshake -> after the edge load=1, rd_addr=5, rd_i=that value; next cycle load=0.
- Contention: a_valid held 1 (addr 3), b_valid held 1 (addr 7, data 64'h1234) with MaxWait=4:
  - A granted 4 consecutive cycles, then exactly one B grant (rd_addr=7), then A resumes.
  - Counter returns to 0.
- x0 write: b transfer with b_addr=0, data 64'hFFFF -> b_ready=1, load stays 0.
- Stability: b_valid=1 with a_valid=1 for 2 cycles, then b_valid dropped -> counter clears; boost never set; no B write.
- Bypass (WB_BYPASS_EN): A write to x9 with rs1_addr=9, rs2_addr=0 -> rs1_hit=1, rs2_hit=0, fwd_o equals the data during the load cycle. Without the macro the ports do not exist.
